// File: rtl/chunked_addsub.sv
// Purpose: WIDTH-bit add/subtract evaluated CHUNK bits per clock with a registered inter-chunk carry.
// Latency: start sampled at edge E0 -> done pulses after edge E0+N (N = WIDTH/CHUNK); one op per N+1 cycles.
// Backpressure: none; start is ignored while busy, results hold from done until the next accepted start.
module chunked_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  // Reject parameter sets that would leave a partial final chunk.
  generate
    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
      $fatal(1, "chunked_addsub: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;      // already inverted for subtract
  logic              carry_q;  // carry into the chunk selected by idx
  logic [IDXW-1:0]   idx;
  int                base;
  logic [CHUNK-1:0]  a_chunk;
  logic [CHUNK-1:0]  b_chunk;
  logic [CHUNK:0]    chunk_sum;
  logic              last_chunk;

  // Slice the current chunk out of the latched operands and add it with the running carry.
  always_comb begin
    base       = int'(idx) * CHUNK;
    a_chunk    = a_q[base +: CHUNK];
    b_chunk    = b_q[base +: CHUNK];
    chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    last_chunk = (idx == LAST_IDX);
  end

  // Control FSM with all outputs registered; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            // Subtract is a + ~b + 1; a borrow-in cancels that +1.
            carry_q <= carry_in ^ sub;
            idx     <= '0;
            result  <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          result[base +: CHUNK] <= chunk_sum[CHUNK-1:0];
          carry_q               <= chunk_sum[CHUNK];
          if (last_chunk) begin
            idx       <= '0;
            carry_out <= chunk_sum[CHUNK];
            // Operands of equal sign producing a result of the other sign.
            overflow  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                         (chunk_sum[CHUNK-1] != a_q[WIDTH-1]);
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
